// File: rtl/token_bucket_arbiter.sv
// Round-robin arbiter for one shared issue slot. Each requester is rate limited by its own
// token bucket: add the refill first, saturate, then deduct on grant.

module tba_bucket #(
   parameter int TW         = 8,
   parameter int RATE_W     = 8,
   parameter int TOK_MAX    = 128,
   parameter int RATE_NUM   = 3,
   parameter int TOKEN_COST = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rate_we,
   input  logic [RATE_W-1:0] rate_wdata,
   input  logic              win,
   output logic              post_ok,
   output logic              ready
);
   localparam int AW = TW + RATE_W + 1;
   localparam logic [AW-1:0] SAT  = AW'(TOK_MAX);
   localparam logic [TW-1:0] COST = TW'(TOKEN_COST);

   logic [TW-1:0]     tokens, post;
   logic [RATE_W-1:0] rate;
   logic [AW-1:0]     sum;

   // The sum is wide enough that saturation is always seen before the value wraps.
   assign sum     = AW'(tokens) + AW'(rate);
   assign post    = (sum > SAT) ? TW'(TOK_MAX) : sum[TW-1:0];
   assign post_ok = (post >= COST);
   assign ready   = (tokens >= COST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tokens <= TW'(TOK_MAX);
         rate   <= RATE_W'(RATE_NUM);
      end else begin
         // A grant is only issued when post_ok is set, so this subtraction cannot underflow.
         tokens <= win ? post - COST : post;
         if (rate_we) rate <= rate_wdata;
      end
   end
endmodule

module token_bucket_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DEN        = 16,
   parameter int RATE_NUM   = 3,
   parameter int BURST_MAX  = 8,
   parameter int TOKEN_COST = DEN,
   parameter int RATE_W     = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic                       out_ready_i,
   input  logic                       cfg_we_i,
   input  logic [$clog2(NUM_REQ)-1:0] cfg_idx_i,
   input  logic [RATE_W-1:0]          cfg_rate_i,
   output logic [NUM_REQ-1:0]         grant_o,
   output logic                       grant_valid_o,
   output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
   output logic [NUM_REQ-1:0]         ready_o
);
   localparam int TOK_MAX = BURST_MAX * DEN;
   localparam int TW      = $clog2(TOK_MAX + 1);
   localparam int IW      = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] post_ok, elig, win_oh;
   logic [IW-1:0]      rr_ptr, win_idx;
   logic               found;
   int                 idx;

   // An out-of-range index never matches any lane, so that write is simply dropped.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      tba_bucket #(
         .TW(TW), .RATE_W(RATE_W), .TOK_MAX(TOK_MAX),
         .RATE_NUM(RATE_NUM), .TOKEN_COST(TOKEN_COST)
      ) u_bkt (
         .clk        (clk),
         .rst_n      (rst_n),
         .rate_we    (cfg_we_i && (cfg_idx_i == IW'(i))),
         .rate_wdata (cfg_rate_i),
         .win        (win_oh[i]),
         .post_ok    (post_ok[i]),
         .ready      (ready_o[i])
      );
   end

   assign elig = req_i & {NUM_REQ{out_ready_i}} & post_ok;

   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      win_oh  = '0;
      idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!found && elig[idx]) begin
            found   = 1'b1;
            win_idx = IW'(idx);
         end
      end
      if (found) win_oh[win_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr        <= '0;
         grant_o       <= '0;
         grant_valid_o <= 1'b0;
         grant_id_o    <= '0;
      end else begin
         grant_o       <= win_oh;
         grant_valid_o <= found;
         grant_id_o    <= found ? win_idx : '0;
         if (found) rr_ptr <= IW'((int'(win_idx) + 1) % NUM_REQ);
      end
   end
endmodule

// File: tb/tb_token_bucket_arbiter.sv
// Directed and random checks of token_bucket_arbiter against a cycle-level post-add bucket
// model, using a queue of expected outputs.

module tb_token_bucket_arbiter;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req_i = '0;
   logic         out_ready_i = 1'b0;
   logic         cfg_we_i = 1'b0;
   logic [1:0]   cfg_idx_i = '0;
   logic [7:0]   cfg_rate_i = '0;
   logic [N-1:0] grant_o;
   logic         grant_valid_o;
   logic [1:0]   grant_id_o;
   logic [N-1:0] ready_o;

   token_bucket_arbiter dut (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .out_ready_i(out_ready_i),
      .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_rate_i(cfg_rate_i),
      .grant_o(grant_o), .grant_valid_o(grant_valid_o), .grant_id_o(grant_id_o),
      .ready_o(ready_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] gnt;
      logic         vld;
      logic [1:0]   id;
      logic [N-1:0] rdy;
      logic [N-1:0] req;
   } exp_t;

   exp_t sbq[$];
   int   n_vec = 0, n_err = 0;
   int   tok[N], rate_m[N], rr;
   int   mcnt[N], dcnt[N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin tok[i] = 128; rate_m[i] = 3; end
      rr = 0;
   endtask

   task automatic model_edge(input logic [N-1:0] req, input logic rdy, input logic we,
                             input logic [1:0] idx, input logic [7:0] rate, output exp_t e);
      int  post[N];
      bit  found;
      int  w, j;
      found = 0; w = 0;
      for (int i = 0; i < N; i++) begin
         post[i] = tok[i] + rate_m[i];
         if (post[i] > 128) post[i] = 128;
      end
      for (int k = 0; k < N; k++) begin
         j = (rr + k) % N;
         if (!found && req[j] && rdy && post[j] >= 16) begin found = 1; w = j; end
      end
      for (int i = 0; i < N; i++) tok[i] = post[i] - ((found && i == w) ? 16 : 0);
      if (found) begin rr = (w + 1) % N; mcnt[w]++; end
      if (we) rate_m[idx] = int'(rate);
      e.gnt = '0;
      if (found) e.gnt[w] = 1'b1;
      e.vld = found;
      e.id  = found ? 2'(w) : 2'd0;
      for (int i = 0; i < N; i++) e.rdy[i] = (tok[i] >= 16);
      e.req = req;
   endtask

   task automatic step(input logic [N-1:0] req, input logic rdy, input logic we = 1'b0,
                       input logic [1:0] idx = 2'd0, input logic [7:0] rate = 8'd0);
      exp_t e;
      @(negedge clk);
      req_i = req; out_ready_i = rdy; cfg_we_i = we; cfg_idx_i = idx; cfg_rate_i = rate;
      model_edge(req, rdy, we, idx, rate, e);
      sbq.push_back(e);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk("grant_o", 32'(grant_o), 32'(e.gnt));
      chk("grant_valid_o", 32'(grant_valid_o), 32'(e.vld));
      chk("grant_id_o", 32'(grant_id_o), 32'(e.id));
      chk("ready_o", 32'(ready_o), 32'(e.rdy));
      chk("grant_wo_req", 32'(grant_o & ~e.req), 32'd0);
      if (grant_valid_o) dcnt[grant_id_o]++;
   endtask

   // Asserts reset between clock edges and checks the outputs before any edge arrives.
   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_i = '0; out_ready_i = 1'b0; cfg_we_i = 1'b0;
      #2;
      chk("rst_grant_o", 32'(grant_o), 32'd0);
      chk("rst_grant_valid", 32'(grant_valid_o), 32'd0);
      chk("rst_grant_id", 32'(grant_id_o), 32'd0);
      chk("rst_ready_o", 32'(ready_o), 32'hF);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic scen_all_req();
      for (int c = 0; c < 16; c++) begin
         step(4'hF, 1'b1);
         chk("s1_id_seq", 32'(grant_id_o), 32'(c % 4));
         chk("s1_valid", 32'(grant_valid_o), 32'd1);
         chk("s1_onehot", 32'($countones(grant_o)), 32'd1);
      end
   endtask

   initial begin
      int g;
      logic [11:0] s2_pat;
      logic [7:0]  r;
      s2_pat = 12'b1001_1111_1111;

      for (int i = 0; i < N; i++) begin mcnt[i] = 0; dcnt[i] = 0; end
      model_reset();
      apply_reset();

      // Scenario 1: everyone requesting.
      scen_all_req();

      // Scenario 2: lone client 2, burst drain then steady state.
      apply_reset();
      for (int c = 0; c < 12; c++) begin
         step(4'b0100, 1'b1);
         chk("s2_valid_pattern", 32'(grant_valid_o), 32'(s2_pat[c]));
      end
      g = 0;
      for (int c = 0; c < 160; c++) begin
         step(4'b0100, 1'b1);
         g += int'(grant_valid_o);
      end
      chk("s2_steady_grants", 32'(g), 32'd30);

      // Scenario 3: downstream stall freezes rr_ptr and lets buckets saturate.
      apply_reset();
      step(4'hF, 1'b1);
      step(4'hF, 1'b1);
      g = 0;
      for (int c = 0; c < 10; c++) begin
         step(4'hF, 1'b0);
         g += int'(grant_valid_o);
      end
      chk("s3_no_grant_stalled", 32'(g), 32'd0);
      chk("s3_ready_full", 32'(ready_o), 32'hF);
      step(4'hF, 1'b1);
      chk("s3_first_after_stall", 32'(grant_id_o), 32'd2);

      // Scenario 4: rate 0 drains client 1, then restored rate refills it.
      apply_reset();
      step(4'b0000, 1'b1, 1'b1, 2'd1, 8'd0);
      g = 0;
      for (int c = 0; c < 12; c++) begin
         step(4'b0010, 1'b1);
         g += int'(grant_valid_o);
      end
      chk("s4_drain_grants", 32'(g), 32'd8);
      chk("s4_ready_drained", 32'(ready_o[1]), 32'd0);
      step(4'b0010, 1'b1, 1'b1, 2'd1, 8'd3);
      chk("s4_write_edge_nogrant", 32'(grant_valid_o), 32'd0);
      for (int c = 1; c <= 6; c++) begin
         step(4'b0010, 1'b1);
         chk("s4_refill_grant", 32'(grant_valid_o), (c == 6) ? 32'd1 : 32'd0);
      end

      // Scenario 5: reset mid-burst, then the same sequence as scenario 1.
      apply_reset();
      for (int c = 0; c < 5; c++) step(4'hF, 1'b1);
      apply_reset();
      scen_all_req();

      // Scenario 6: random traffic against the model.
      apply_reset();
      for (int i = 0; i < N; i++) begin mcnt[i] = 0; dcnt[i] = 0; end
      for (int c = 0; c < 1000; c++) begin
         logic [N-1:0] rq;
         for (int i = 0; i < N; i++) rq[i] = ($urandom_range(0, 99) < 30);
         r = ($urandom_range(0, 4) == 0) ? 8'd200 : 8'($urandom_range(0, 6));
         step(rq, $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 3,
              2'($urandom_range(0, 3)), r);
      end
      for (int i = 0; i < N; i++) chk("s6_grant_count", 32'(dcnt[i]), 32'(mcnt[i]));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/token_bucket_arbiter.md
Name: token_bucket_arbiter

Overview:
- Shares one downstream issue slot among NUM_REQ requesters. Each requester has its own token bucket, with a programmable refill rate.
- Each cycle, at most one eligible requester is granted, chosen round-robin. A requester is eligible when it has enough tokens after accrual and downstream is ready.
- Sits between client request lines and the shared resource. It enforces per-client average rate and burst limits plus fair arbitration.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DEN, 16, tokens per request unit.
- RATE_NUM, 3, reset value of every per-client refill rate, in tokens/cycle.
- BURST_MAX, 8, maximum requests' worth buffered per bucket; TOK_MAX = BURST_MAX*DEN.
- TOKEN_COST, DEN, tokens deducted per grant.
- RATE_W, 8, width of a rate config value.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- req_i, in, NUM_REQ, per-client request level.
- out_ready_i, in, 1, downstream can accept an issue this cycle.
- cfg_we_i, in, 1, rate write strobe.
- cfg_idx_i, in, clog2(NUM_REQ), client index for the write.
- cfg_rate_i, in, RATE_W, new refill rate.
- grant_o, out, NUM_REQ, registered one-hot grant.
- grant_valid_o, out, 1, registered; equals |grant_o.
- grant_id_o, out, clog2(NUM_REQ), registered index of the granted client; 0 when no grant.
- ready_o, out, NUM_REQ, registered; bit i = (tokens_i >= TOKEN_COST).

Behaviour:
- Reset (async assert, sync-safe release):
  - tokens_i = TOK_MAX, rate_i = RATE_NUM, rr_ptr = 0.
  - grant_o = 0, grant_valid_o = 0, grant_id_o = 0, ready_o = all ones.
- Token width TW = clog2(TOK_MAX+1). Accrual is computed in TW+RATE_W+1 bits, so there is no overflow before saturation.
- Per posedge, all clients in parallel, post-add semantics:
  1. post_i = min(tokens_i + rate_i, TOK_MAX).
  2. elig_i = req_i & out_ready_i & (post_i >= TOKEN_COST).
  3. Winner = first eligible index scanning rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ.
  4. The winner's tokens_i <= post_i - TOKEN_COST; all other clients' tokens_i <= post_i.
  5. If there is a winner: rr_ptr <= (winner+1) mod NUM_REQ, grant_o <= one-hot(winner), grant_valid_o <= 1, grant_id_o <= winner.
  6. If there is no winner: rr_ptr holds and grant outputs are 0.
- Latency: the decision uses req_i sampled at the edge, and grant_o is visible immediately after that edge. There are no held grants; the grant is re-evaluated every cycle.
- Request without tokens gets no grant; the request is not queued.
- Grant without request never occurs.
- out_ready_i = 0:
  - No grant, no token deduction, rr_ptr frozen.
  - Accrual continues, saturating at TOK_MAX.
- Config write (cfg_we_i at edge):
  - rate[cfg_idx_i] <= cfg_rate_i. The accrual at the same edge uses the old rate; the new rate applies from the next edge.
  - cfg_idx_i >= NUM_REQ: the write is ignored.
- rate = 0: the bucket only drains; it can still grant while tokens remain.
- rate >= TOK_MAX: the bucket saturates every cycle.
- ready_o reflects the registered tokens after the edge. It is advisory and does not include the next cycle's accrual.
- Reset asserted mid-operation: all state and outputs return to reset values immediately, asynchronously. The first decision after release uses full buckets and rr_ptr = 0.

Test Plan (defaults: NUM_REQ=4, DEN=16, RATE=3, BURST=8, COST=16, TOK_MAX=128):
1. After reset, req_i = 4'b1111 and out_ready_i = 1 held for 16 cycles -> grant_id_o sequence 0,1,2,3 repeating, grant_valid_o = 1 every cycle, never two bits set in grant_o.
2. Only req_i[2] held, others 0:
   - Grants on cycles 1–9; client 2 tokens after each grant: 112, 99, 86, 73, 60, 47, 34, 21, 8.
   - No grant on cycles 10–11; grant on cycle 12 (tokens 1).
   - Long-run grant ratio converges to 3/16.
3. All requesting, out_ready_i = 0 for 10 cycles -> no grants, rr_ptr unchanged, tokens saturate at 128. On release, the first grant goes to the client at rr_ptr.
4. cfg write of rate 0 to client 1, then only req_i[1] held -> exactly 8 grants (128 -> 0), then none. Write rate 3 back -> the next grant occurs when post-add tokens reach 16 (6th cycle after the write edge).
5. Assert rst_n low mid-burst, between clock edges -> grant_o = 0 and ready_o = 4'b1111 immediately, without a clock. After release, behaviour matches scenario 1 from the start.
6. 1000 cycles of random req_i (30%) with out_ready_i random (80%) and occasional cfg writes -> cycle-exact match against a per-client post-add reference model with round-robin selection. Zero mismatches, zero grant-without-request, and per-client grant counts equal to the model's.
